// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and control-vector constants for the pipeline sequencer
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALTED   = 2'd3
  } state_t;
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_hold;
  } ctrl_t;
  localparam ctrl_t CTRL_IDLE  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_HALT  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with sync clear (clock, reset async-high, clear, inc -> count[W])
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer: merges halt/memstall/flush/load-use into prioritised PC, IF/ID, ID/EX and hold controls plus stall/flush counters
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt,
  input  logic             clear_counters,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  state_t st, st_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  ctrl_t c;
  logic memstall, ctrl;
  assign memstall = mem_req & ~mem_ready;
  assign ctrl = branch_taken | jump;
  always_comb begin
    c = CTRL_IDLE;
    st_nxt = RUN;
    fcnt_nxt = fcnt;
    if (st == HALTED || halt) begin
      c = CTRL_HALT;
      st_nxt = HALTED;
    end else if (memstall) begin
      c = CTRL_HOLD;
      st_nxt = MEM_WAIT;
    end else if (st == FLUSH) begin
      c = CTRL_FLUSH;
      fcnt_nxt = fcnt - 4'd1;
      st_nxt = (fcnt == 4'd1) ? RUN : FLUSH;
    end else if (ctrl) begin
      c = CTRL_FLUSH;
      fcnt_nxt = FLUSH_INIT;
      st_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (load_use_hazard) begin
      c = CTRL_STALL;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st <= RUN;
      fcnt <= '0;
    end else begin
      st <= st_nxt;
      fcnt <= fcnt_nxt;
    end
  // reset forces the pipeline to free-run so nothing stays frozen while it is held
  assign {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold} = reset ? CTRL_IDLE : c;
  assign state = st;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock(clock),
    .reset(reset),
    .clear(clear_counters),
    .inc  (~c.pc_write & (st != HALTED) & ~halt),
    .count(stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock(clock),
    .reset(reset),
    .clear(clear_counters),
    .inc  (c.if_id_flush),
    .count(flush_count)
  );
endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb_pipeline_stall_sequencer: directed plus random checks of two sequencer configurations against a behavioural model
module tb_pipeline_stall_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load_use_hazard = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0, halt = 1'b0, clear_counters = 1'b0;
  wire [4:0] ctl0, ctl1;
  wire [1:0] st0, st1;
  wire [3:0] sc0, fc0;
  wire [15:0] sc1, fc1;
  int compared = 0, mismatched = 0;
  int fcp[2] = '{3, 1};
  int maxc[2] = '{15, 65535};
  bit halted[2], in_mw[2];
  int left[2], scm[2], fcm[2];

  always #5 clock = ~clock;

  pipeline_stall_sequencer #(.FLUSH_CYCLES(3), .CNT_W(4)) dut0 (
    .clock(clock), .reset(reset), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
    .jump(jump), .mem_req(mem_req), .mem_ready(mem_ready), .halt(halt), .clear_counters(clear_counters),
    .pc_write(ctl0[4]), .if_id_write(ctl0[3]), .if_id_flush(ctl0[2]), .id_ex_bubble(ctl0[1]),
    .pipe_hold(ctl0[0]), .state(st0), .stall_count(sc0), .flush_count(fc0)
  );
  pipeline_stall_sequencer #(.FLUSH_CYCLES(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
    .jump(jump), .mem_req(mem_req), .mem_ready(mem_ready), .halt(halt), .clear_counters(clear_counters),
    .pc_write(ctl1[4]), .if_id_write(ctl1[3]), .if_id_flush(ctl1[2]), .id_ex_bubble(ctl1[1]),
    .pipe_hold(ctl1[0]), .state(st1), .stall_count(sc1), .flush_count(fc1)
  );

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  function automatic logic [4:0] exp_ctl(int k);
    if (reset) return 5'b11000;
    if (halted[k] || halt) return 5'b00010;
    if (mem_req && !mem_ready) return 5'b00001;
    if (left[k] > 0 || branch_taken || jump) return 5'b11110;
    if (load_use_hazard) return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic int exp_state(int k);
    return halted[k] ? 3 : left[k] > 0 ? 2 : in_mw[k] ? 1 : 0;
  endfunction

  task automatic update(input int k, input logic [4:0] e);
    bit sinc = !e[4] && !halted[k] && !halt;
    bit finc = e[2];
    scm[k] = clear_counters ? 0 : (sinc && scm[k] < maxc[k]) ? scm[k] + 1 : scm[k];
    fcm[k] = clear_counters ? 0 : (finc && fcm[k] < maxc[k]) ? fcm[k] + 1 : fcm[k];
    if (halted[k] || halt) halted[k] = 1;
    else if (mem_req && !mem_ready) begin in_mw[k] = 1; left[k] = 0; end
    else if (left[k] > 0) begin left[k]--; in_mw[k] = 0; end
    else if (branch_taken || jump) begin left[k] = fcp[k] - 1; in_mw[k] = 0; end
    else in_mw[k] = 0;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s[dut%0d] t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic step(input logic r, lu, br, j, mr, my, h, clr);
    logic [4:0] e[2];
    @(negedge clock);
    reset = r; load_use_hazard = lu; branch_taken = br; jump = j;
    mem_req = mr; mem_ready = my; halt = h; clear_counters = clr;
    if (r) for (int k = 0; k < 2; k++) begin
      halted[k] = 0; in_mw[k] = 0; left[k] = 0; scm[k] = 0; fcm[k] = 0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e[k] = exp_ctl(k);
      chk("ctl", k, 32'(k == 0 ? ctl0 : ctl1), 32'(e[k]));
      chk("state", k, 32'(k == 0 ? st0 : st1), 32'(exp_state(k)));
      chk("stall_count", k, k == 0 ? 32'(sc0) : 32'(sc1), 32'(scm[k]));
      chk("flush_count", k, k == 0 ? 32'(fc0) : 32'(fc1), 32'(fcm[k]));
    end
    @(posedge clock);
    if (!r) for (int k = 0; k < 2; k++) update(k, e[k]);
  endtask

  initial begin
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (10) step(0, 1, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (600) step($urandom % 60 == 0, $urandom % 4 == 0, $urandom % 6 == 0, $urandom % 8 == 0,
                      $urandom % 3 == 0, $urandom % 2 == 0, $urandom % 120 == 0, $urandom % 25 == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
